// File: rtl/tdc_hw_stats.sv
// tdc_hw_stats: per-run sum/min/max of TDC hamming-weight samples with a
// registered byte-wide readout mux. Single clock domain (clk_capture).
module tdc_hw_stats #(
    parameter int unsigned N_O    = 6,
    parameter int unsigned LOG2_S = 4
) (
    input  logic           clk_capture,
    input  logic           rst,
    input  logic           start,
    input  logic           hw_valid,
    input  logic [N_O:0]   hw,
    input  logic [2:0]     rd_sel,
    output logic           busy,
    output logic           done,
    output logic [7:0]     dout
);

    localparam int unsigned SUM_W = N_O + 1 + LOG2_S;
    localparam int unsigned CNT_W = LOG2_S + 1;

    localparam logic [CNT_W-1:0] CntFull = {1'b1, {LOG2_S{1'b0}}};
    localparam logic [N_O:0]     MinInit = {(N_O + 1){1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [N_O:0]       min_q, min_d;
    logic [N_O:0]       max_q, max_d;
    logic [7:0]         dout_q, dout_d;

    logic [15:0]        sum_ext;
    logic [SUM_W-1:0]   mean;

    assign busy = (state_q == StAccum);
    assign done = (state_q == StDone);
    assign dout = dout_q;

    // Run FSM and statistics accumulation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        unique case (state_q)
            StIdle, StDone: begin
                // A sample coinciding with start is dropped along with the old stats.
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    sum_d   = '0;
                    min_d   = MinInit;
                    max_d   = '0;
                end
            end
            StAccum: begin
                if (hw_valid) begin
                    sum_d = sum_q + SUM_W'(hw);
                    if (hw < min_q) min_d = hw;
                    if (hw > max_q) max_d = hw;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntFull) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Readout mux; registered so dout follows rd_sel by one cycle.
    always_comb begin
        sum_ext = 16'(sum_q);
        mean    = sum_q >> LOG2_S;
        dout_d  = 8'h00;
        unique case (rd_sel)
            3'd0: dout_d = sum_ext[7:0];
            3'd1: dout_d = sum_ext[15:8];
            3'd2: dout_d = 8'(min_q);
            3'd3: dout_d = 8'(max_q);
            3'd4: dout_d = 8'(mean);
            3'd5: dout_d = 8'(cnt_q);
            3'd6: dout_d = {6'b0, done, busy};
            default: dout_d = 8'h00;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= MinInit;
            max_q   <= '0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            dout_q  <= dout_d;
        end
    end

endmodule
